// File: rtl/uart_word_sender.sv
// Serializes one DBITS*NBYTES word as NBYTES back-to-back UART frames, byte 0 first, LSB first.
// Optional even-parity bit per frame when UART_WORD_SENDER_PARITY_EN is defined.
module uart_word_sender #(
  parameter int DBITS    = 8,
  parameter int NBYTES   = 16,
  parameter int SB_TICK  = 16,
  parameter int BR_LIMIT = 651,
  parameter int BR_BITS  = 10
) (
  input  logic                      clk_100MHz,
  input  logic                      reset,
  input  logic [DBITS*NBYTES-1:0]   word_in,
  input  logic                      word_valid,
  output logic                      word_ready,
  output logic                      tx,
  output logic                      busy,
  output logic                      byte_done,
  output logic                      word_done
);

  localparam int WORD_W = DBITS * NBYTES;
  localparam int BIT_W  = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [BR_BITS-1:0] BR_LAST   = BR_BITS'(BR_LIMIT - 1);
  localparam logic [4:0]         OS_LAST   = 5'd15;
  localparam logic [4:0]         SB_LAST   = 5'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(DBITS - 1);
  localparam logic [BYTE_W-1:0]  BYTE_LAST = BYTE_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

`ifdef UART_WORD_SENDER_PARITY_EN
  function automatic logic even_parity(input logic [DBITS-1:0] d);
    return ^d;
  endfunction
`endif

  state_t              state_r, state_s;
  logic [BR_BITS-1:0]  baud_r, baud_s;
  logic [4:0]          os_r, os_s;
  logic [BIT_W-1:0]    bit_r, bit_s;
  logic [BYTE_W-1:0]   byte_r, byte_s;
  logic [WORD_W-1:0]   shreg_r, shreg_s;
  logic                tx_r, tx_s;
  logic                ready_r, busy_r;
  logic                baud_tick_s;
  logic                byte_end_s, word_end_s;
  logic [DBITS-1:0]    next_byte_s;

  assign baud_tick_s = (baud_r == BR_LAST);

  // Next-state, counters and shift register
  always_comb begin
    state_s    = state_r;
    baud_s     = baud_r;
    os_s       = os_r;
    bit_s      = bit_r;
    byte_s     = byte_r;
    shreg_s    = shreg_r;
    byte_end_s = 1'b0;
    word_end_s = 1'b0;

    if (state_r != IDLE) begin
      if (baud_tick_s) begin
        baud_s = '0;
        os_s   = os_r + 5'd1;
      end else begin
        baud_s = baud_r + BR_BITS'(1);
      end
    end else begin
      baud_s = baud_r;
    end

    case (state_r)
      IDLE: begin
        if (word_valid) begin
          state_s = START;
          shreg_s = word_in;
          baud_s  = '0;
          os_s    = '0;
          bit_s   = '0;
          byte_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_tick_s && (os_r == OS_LAST)) begin
          state_s = DATA;
          os_s    = '0;
          bit_s   = '0;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (baud_tick_s && (os_r == OS_LAST)) begin
          os_s = '0;
          if (bit_r == BIT_LAST) begin
`ifdef UART_WORD_SENDER_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            bit_s = bit_r + BIT_W'(1);
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef UART_WORD_SENDER_PARITY_EN
      PARITY: begin
        if (baud_tick_s && (os_r == OS_LAST)) begin
          state_s = STOP;
          os_s    = '0;
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (baud_tick_s && (os_r == SB_LAST)) begin
          byte_end_s = 1'b1;
          shreg_s    = shreg_r >> DBITS;
          os_s       = '0;
          bit_s      = '0;
          if (byte_r == BYTE_LAST) begin
            word_end_s = 1'b1;
            state_s    = IDLE;
          end else begin
            byte_s  = byte_r + BYTE_W'(1);
            state_s = START;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Line level for the upcoming cycle, so tx leaves a flop
  always_comb begin
    next_byte_s = shreg_s[DBITS-1:0];
    tx_s        = 1'b1;
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = next_byte_s[bit_s];
`ifdef UART_WORD_SENDER_PARITY_EN
      PARITY:  tx_s = even_parity(next_byte_s);
`endif
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_r <= IDLE;
      baud_r  <= '0;
      os_r    <= '0;
      bit_r   <= '0;
      byte_r  <= '0;
      shreg_r <= '0;
      tx_r    <= 1'b1;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      os_r    <= os_s;
      bit_r   <= bit_s;
      byte_r  <= byte_s;
      shreg_r <= shreg_s;
      tx_r    <= tx_s;
      ready_r <= (state_s == IDLE);
      busy_r  <= (state_s != IDLE);
    end
  end

  // Done pulses mark the last clock of a stop bit; word_ready follows one clock later.
  assign byte_done  = byte_end_s & ~reset;
  assign word_done  = word_end_s & ~reset;
  assign tx         = tx_r;
  assign word_ready = ready_r;
  assign busy       = busy_r;

endmodule
